// File: rtl/vga_pkg.sv
// vga_pkg: shared character alphabet, default 640x480@60 timing and the 4:4:4 colour type
package vga_pkg;
  typedef logic [11:0] rgb_t;
  localparam int H_VIS_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_VIS_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int GLYPHS = 37;
  localparam logic [7:0] ZERO = 8'h00, UNO = 8'h01, DOS = 8'h02, TRES = 8'h03, CUATRO = 8'h04;
  localparam logic [7:0] CINCO = 8'h05, SEIS = 8'h06, SIETE = 8'h07, OCHO = 8'h08, NUEVE = 8'h09;
  localparam logic [7:0] A = 8'h0A, B = 8'h0B, C = 8'h0C, D = 8'h0D, E = 8'h0E, F = 8'h0F;
  localparam logic [7:0] G = 8'h10, H = 8'h11, I = 8'h12, J = 8'h13, K = 8'h14, L = 8'h15;
  localparam logic [7:0] M = 8'h16, N = 8'h17, O = 8'h18, P = 8'h19, Q = 8'h1A, R = 8'h1B;
  localparam logic [7:0] S = 8'h1C, T = 8'h1D, U = 8'h1E, V = 8'h1F, W = 8'h20, X = 8'h21;
  localparam logic [7:0] Y = 8'h22, Z = 8'h23, ESPACIO = 8'h24;
endpackage

// File: rtl/vga_font_rom.sv
// vga_font_rom: 37x16x8 glyph ROM (8x8 art with every row doubled, bit 7 leftmost), registered on ce_i; code_i/line_i in, bits_o out, codes >36 give zero rows
module vga_font_rom
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_i,
  input  logic [5:0] code_i,
  input  logic [3:0] line_i,
  output logic [7:0] bits_o
);
  localparam logic [0:GLYPHS-1][63:0] FONT = {
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
    64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
    64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000,
    64'h3C66606E66663C00, 64'h6666667E66666600, 64'h3C18181818183C00, 64'h1E0C0C0C0C6C3800,
    64'h666C7870786C6600, 64'h6060606060607E00, 64'h63777F6B63636300, 64'h66767E7E6E666600,
    64'h3C66666666663C00, 64'h7C66667C60606000, 64'h3C666666663C0E00, 64'h7C66667C786C6600,
    64'h3C66603C06663C00, 64'h7E18181818181800, 64'h6666666666663C00, 64'h66666666663C1800,
    64'h6363636B7F776300, 64'h66663C183C666600, 64'h6666663C18181800, 64'h7E060C1830607E00,
    64'h0000000000000000
  };
  logic [63:0] glyph;
  logic [7:0] bits_d, bits_q;
  always_comb begin
    glyph = code_i > 6'(GLYPHS - 1) ? '0 : FONT[code_i];
    bits_d = glyph[{~line_i[3:1], 3'b000} +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bits_q <= '0;
    else if (ce_i) bits_q <= bits_d;
  assign bits_o = bits_q;
endmodule

// File: rtl/vga_text_render.sv
// vga_text_render: 640x480 character-cell renderer; presents col_o/row_o, takes char_i back, drives rgb_o/hsync_o/vsync_o three pix_ce_i ticks later plus a frame_start_o pulse
module vga_text_render
  import vga_pkg::*;
#(
  parameter rgb_t FG_RGB = 12'hFFF,
  parameter rgb_t BG_RGB = 12'h000,
  parameter int H_VIS = H_VIS_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_VIS = V_VIS_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce_i,
  output logic [6:0]  col_o,
  output logic [4:0]  row_o,
  input  logic [7:0]  char_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] rgb_o,
  output logic        frame_start_o
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic h_end, v_end, active, hs_raw, vs_raw;
  logic [7:0] char_q, glyph_bits;
  logic [5:0] rom_code;
  logic [3:0] line_q;
  logic [2:0] bit1_q, bit2_q;
  logic act1_q, act2_q, hs1_q, hs2_q, vs1_q, vs2_q;
  logic hsync_q, vsync_q, frame_start_q;
  rgb_t rgb_q, rgb_d;
  always_comb begin
    h_end = hcnt_q == 10'(H_TOTAL - 1);
    v_end = vcnt_q == 10'(V_TOTAL - 1);
    hcnt_d = h_end ? '0 : hcnt_q + 10'd1;
    vcnt_d = h_end ? (v_end ? '0 : vcnt_q + 10'd1) : vcnt_q;
    active = hcnt_q < 10'(H_VIS) && vcnt_q < 10'(V_VIS);
    hs_raw = !(hcnt_q >= 10'(H_VIS + H_FP) && hcnt_q < 10'(H_VIS + H_FP + H_SYNC));
    vs_raw = !(vcnt_q >= 10'(V_VIS + V_FP) && vcnt_q < 10'(V_VIS + V_FP + V_SYNC));
    rom_code = char_q > ESPACIO ? 6'h3F : char_q[5:0];
    rgb_d = act2_q ? (glyph_bits[~bit2_q] ? FG_RGB : BG_RGB) : '0;
  end
  vga_font_rom u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce_i   (pix_ce_i),
    .code_i (rom_code),
    .line_i (line_q),
    .bits_o (glyph_bits)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      frame_start_q <= 1'b0;
      char_q <= '0;
      line_q <= '0;
      bit1_q <= '0;
      bit2_q <= '0;
      act1_q <= 1'b0;
      act2_q <= 1'b0;
      hs1_q <= 1'b1;
      hs2_q <= 1'b1;
      vs1_q <= 1'b1;
      vs2_q <= 1'b1;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q <= '0;
    end else begin
      frame_start_q <= pix_ce_i && h_end && v_end;
      if (pix_ce_i) begin
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
        char_q <= char_i;
        line_q <= vcnt_q[3:0];
        bit1_q <= hcnt_q[2:0];
        act1_q <= active;
        hs1_q <= hs_raw;
        vs1_q <= vs_raw;
        bit2_q <= bit1_q;
        act2_q <= act1_q;
        hs2_q <= hs1_q;
        vs2_q <= vs1_q;
        rgb_q <= rgb_d;
        hsync_q <= hs2_q;
        vsync_q <= vs2_q;
      end
    end
  assign col_o = hcnt_q[9:3];
  assign row_o = vcnt_q[8:4];
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign rgb_o = rgb_q;
  assign frame_start_o = frame_start_q;
endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: directed vectors plus sequences on a shrunken-timing instance and a default-timing instance
module tb_vga_text_render;
  localparam int HT = 128, VT = 38, FRAME = HT * VT;
  localparam logic [11:0] FG = 12'hFF0, BG = 12'h00F;
  localparam logic [7:0] GA [8] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
  localparam logic [7:0] G1 [8] = '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
  typedef struct {
    int mode;
    int n;
    logic [11:0] rgb;
    logic hs;
    logic vs;
    logic [6:0] col;
    logic [4:0] row;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0;
  logic [6:0] col, col_d;
  logic [4:0] row, row_d;
  logic [7:0] ch;
  logic hs, vs, fs, hs_d, vs_d, fs_d;
  logic [11:0] rgb, rgb_d;
  int mode = 0, n = 0, n_chk = 0, n_fail = 0;
  vec_t vec[$];
  always #5 clk = ~clk;
  function automatic logic [7:0] src(logic [6:0] c, int m);
    return m == 1 ? 8'h0A : m == 2 ? (c == 7'd9 ? 8'h01 : 8'h24) : m == 3 ? 8'h30 : m == 4 ? 8'h4A : 8'h24;
  endfunction
  always_comb ch = src(col, mode);
  vga_text_render #(
    .FG_RGB(FG), .BG_RGB(BG), .H_VIS(96), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_VIS(32), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce_i(pix_ce), .col_o(col), .row_o(row), .char_i(ch),
    .hsync_o(hs), .vsync_o(vs), .rgb_o(rgb), .frame_start_o(fs)
  );
  vga_text_render dut_def (
    .clk(clk), .rst_n(rst_n), .pix_ce_i(pix_ce), .col_o(col_d), .row_o(row_d), .char_i(8'h24),
    .hsync_o(hs_d), .vsync_o(vs_d), .rgb_o(rgb_d), .frame_start_o(fs_d)
  );
  function automatic logic [7:0] glyph(logic [7:0] c, int line);
    return c == 8'h0A ? GA[line / 2] : c == 8'h01 ? G1[line / 2] : 8'h00;
  endfunction
  function automatic logic [13:0] model(int k, int m);
    int p, h, v;
    logic [7:0] g;
    logic [11:0] c;
    if (k < 3) return 14'h3000;
    p = (k - 3) % FRAME;
    h = p % HT;
    v = p / HT;
    g = glyph(src(7'(h / 8), m), v % 16);
    c = (h < 96 && v < 32) ? (g[7 - (h % 8)] ? FG : BG) : 12'h000;
    return {!(h >= 104 && h < 120), !(v >= 34 && v < 36), c};
  endfunction
  function automatic logic [11:0] exp_cr(int k);
    int p;
    p = k % FRAME;
    return {7'((p % HT) / 8), 5'((p / HT) / 16)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
    if (ce) n++;
  endtask
  task automatic do_reset();
    pix_ce = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
  endtask
  initial begin
    #1ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    int bad, bad_cr, bad_fs, bad_def, fs_cnt, low_def;
    logic exp_h;
    logic [25:0] snap;
    vec.push_back('{0, 0, 12'h000, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{0, 2, 12'h000, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{0, 3, BG, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{1, 3, BG, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{1, 6, FG, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{1, 7, FG, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{1, 8, BG, 1'b1, 1'b1, 7'd1, 5'd0});
    vec.push_back('{1, 261, FG, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{2, 75, BG, 1'b1, 1'b1, 7'd9, 5'd0});
    vec.push_back('{2, 78, FG, 1'b1, 1'b1, 7'd9, 5'd0});
    vec.push_back('{2, 70, BG, 1'b1, 1'b1, 7'd8, 5'd0});
    vec.push_back('{2, 86, BG, 1'b1, 1'b1, 7'd10, 5'd0});
    vec.push_back('{2, 1612, FG, 1'b1, 1'b1, 7'd9, 5'd0});
    vec.push_back('{3, 6, BG, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{4, 6, BG, 1'b1, 1'b1, 7'd0, 5'd0});
    vec.push_back('{1, 103, 12'h000, 1'b1, 1'b1, 7'd12, 5'd0});
    vec.push_back('{1, 106, 12'h000, 1'b1, 1'b1, 7'd13, 5'd0});
    vec.push_back('{1, 107, 12'h000, 1'b0, 1'b1, 7'd13, 5'd0});
    vec.push_back('{1, 122, 12'h000, 1'b0, 1'b1, 7'd15, 5'd0});
    vec.push_back('{1, 123, 12'h000, 1'b1, 1'b1, 7'd15, 5'd0});
    vec.push_back('{1, 4354, 12'h000, 1'b1, 1'b1, 7'd0, 5'd2});
    vec.push_back('{1, 4355, 12'h000, 1'b1, 1'b0, 7'd0, 5'd2});
    vec.push_back('{1, 4610, 12'h000, 1'b1, 1'b0, 7'd0, 5'd2});
    vec.push_back('{1, 4611, 12'h000, 1'b1, 1'b1, 7'd0, 5'd2});
    vec.push_back('{1, 4867, BG, 1'b1, 1'b1, 7'd0, 5'd0});
    for (int i = 0; i < vec.size(); i++) begin
      mode = vec[i].mode;
      do_reset();
      repeat (vec[i].n) tick(1'b1);
      chk($sformatf("vec%0d rgb", i), 32'(rgb), 32'(vec[i].rgb));
      chk($sformatf("vec%0d hsync", i), 32'(hs), 32'(vec[i].hs));
      chk($sformatf("vec%0d vsync", i), 32'(vs), 32'(vec[i].vs));
      chk($sformatf("vec%0d col", i), 32'(col), 32'(vec[i].col));
      chk($sformatf("vec%0d row", i), 32'(row), 32'(vec[i].row));
    end
    mode = 1;
    do_reset();
    bad = 0; bad_cr = 0; bad_fs = 0; bad_def = 0; fs_cnt = 0; low_def = 0;
    for (int k = 0; k < 2 * FRAME + 5; k++) begin
      tick(1'b0);
      if (fs !== 1'b0) bad_fs++;
      tick(1'b1);
      if ({hs, vs, rgb} !== model(n, mode)) bad++;
      if ({col, row} !== exp_cr(n)) bad_cr++;
      if (fs === 1'b1) fs_cnt++;
      if (fs !== (n % FRAME == 0)) bad_fs++;
      if (n <= 820) begin
        exp_h = n < 3 || !(n - 3 >= 656 && n - 3 < 752);
        if ({hs_d, vs_d, rgb_d} !== {exp_h, 1'b1, 12'h000}) bad_def++;
        if (hs_d === 1'b0) low_def++;
      end
    end
    chk("scan sync/rgb mismatches", 32'(bad), 32'd0);
    chk("scan col/row mismatches", 32'(bad_cr), 32'd0);
    chk("frame_start timing mismatches", 32'(bad_fs), 32'd0);
    chk("frame_start pulse count", 32'(fs_cnt), 32'd2);
    chk("default hsync mismatches", 32'(bad_def), 32'd0);
    chk("default hsync low ticks", 32'(low_def), 32'd96);
    do_reset();
    repeat (7) tick(1'b1);
    chk("freeze pre rgb", 32'(rgb), 32'(FG));
    snap = {hs, vs, rgb, col, row};
    bad = 0;
    repeat (50) begin
      tick(1'b0);
      if ({hs, vs, rgb, col, row} !== snap) bad++;
    end
    chk("freeze hold changes", 32'(bad), 32'd0);
    bad = 0;
    repeat (10) begin
      tick(1'b1);
      if ({hs, vs, rgb} !== model(n, mode) || {col, row} !== exp_cr(n)) bad++;
    end
    chk("freeze resume mismatches", 32'(bad), 32'd0);
    do_reset();
    repeat (2620) tick(1'b1);
    chk("pre-reset row", 32'(row), 32'd1);
    chk("pre-reset col", 32'(col), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset hsync", 32'(hs), 32'd1);
    chk("async reset vsync", 32'(vs), 32'd1);
    chk("async reset rgb", 32'(rgb), 32'd0);
    chk("async reset col/row", 32'({col, row}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    bad = 0;
    repeat (8) begin
      tick(1'b1);
      if ({hs, vs, rgb} !== model(n, mode) || {col, row} !== exp_cr(n)) bad++;
    end
    chk("restart mismatches", 32'(bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_text_render.md
# vga_text_render

Character-cell VGA renderer: the consuming end of the column→character-code interface driven by the per-stage text-line sources (fetch, decode, etc.). It generates 640×480@60 timing and presents the current character column and row to a source. It then takes back an 8-bit character code in the team's 0x00–0x24 alphabet, expands it through an 8×16 glyph ROM and drives pipeline-aligned RGB and sync. It sits between the character sources and the board's VGA pins.

## Interface
Parameters:
- FG_RGB, 12'hFFF, foreground colour (4:4:4)
- BG_RGB, 12'h000, background colour inside the visible area
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel-clock enable, one clk pulse per pixel (25 MHz from 50 MHz)
- col  out  7  character column = hcnt[9:3]
- row  out  5  character row = vcnt[8:4]
- char  in  8  character code from the source for (col,row), combinational in the source
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- rgb  out  12  pixel colour, 0 during blanking
- frame_start  out  1  one-clk pulse at the start of each frame

## Operation
- Counters: hcnt (10 b) 0..H_TOTAL-1 = 0..799. vcnt (10 b) 0..V_TOTAL-1 = 0..524. Both advance only when pix_ce=1.
- hcnt wraps 799→0 and increments vcnt. vcnt wraps 524→0 when hcnt wraps.
- frame_start = 1 for exactly one clk on the edge where (799,524)→(0,0).
- col and row are combinational from the counters. Blanking values (col up to 99, row truncated) are legal; all blanking output is forced to 0.
- active = hcnt<640 && vcnt<480.
- hs_raw = 0 when 656≤hcnt<752. vs_raw = 0 when 490≤vcnt<492.
- Alphabet: 0x00–0x09 are digits '0'–'9'. 0x0A–0x23 are 'A'–'Z'. 0x24 is space. Codes ≥0x25 render as space (glyph all zero).
- Pipeline. Each stage loads only on pix_ce:
  - S1 registers char, glyph line vcnt[3:0], bit index hcnt[2:0], active, hs_raw, vs_raw.
  - S2 is the font ROM. Its registered output is glyph_bits[7:0] for (char, line). Bit index, active and syncs are delayed alongside it.
  - S3 registers rgb = active ? (glyph_bits[7-bitidx] ? FG_RGB : BG_RGB) : 0, and registers hsync and vsync.
- Glyph bit 7 is the leftmost pixel.

## Timing
- Reset values:
  - hcnt = 0, vcnt = 0.
  - All pipeline registers 0, except the delayed syncs, which reset to 1.
  - hsync = 1, vsync = 1, rgb = 0, frame_start = 0.
  - col = 0, row = 0.
- Latency: hsync, vsync and rgb are 3 pix_ce ticks behind the counter value that produced them. Sync-to-pixel alignment is exact because all three share the same delay.
- char is sampled in the same clk cycle in which col/row are presented. A source must be combinational (zero latency).
- pix_ce=0 freezes counters and every pipeline stage. Outputs hold.
- Back-to-back pix_ce (every clk) is legal: one pixel per clk.
- Reset asserted mid-frame clears everything immediately (asynchronous). After release the frame restarts at (0,0), with the first pixel out after 3 pix_ce.
- The first 3 pixels after reset show 0 / sync-inactive, which is the pipeline fill.

## Structure
- Shared package vga_pkg holds:
  - character code constants ZERO..NUEVE, A..Z, ESPACIO = 8'h24
  - H/V timing default localparams
  - the rgb_t typedef (logic [11:0])
- Character sources import the same package so the alphabet is defined once.
- Sub-module vga_font_rom: a 37×16×8 ROM with a registered output. Its inputs are code[5:0] and line[3:0]. Out-of-range codes map to zero rows.
- The top holds the counters, the sync/active decode and the delay registers.

## Test plan
- Reset, then free-run pix_ce every 2nd clk → hsync low for exactly 96 pix_ce, period 800. vsync low for 2 lines, period 525 lines. frame_start every 420000 pix_ce.
- char tied to 8'h24 → rgb = BG_RGB on all 640×480 visible pixels and 0 in blanking.
- char tied to 8'h0A ('A') → the 8 rgb values for line 0 of cell (0,0) match the ROM row bits MSB-first, and appear 3 pix_ce after hcnt=0,vcnt=0.
- Model source returning 8'h01 when col==9 and 8'h24 otherwise → '1' glyph pixels only on hcnt 72..79 (+3 pipeline delay). col observed equals 9 while hcnt is 72..79.
- Hold pix_ce=0 for 50 clk mid-line → hcnt, vcnt, rgb and syncs unchanged. The line resumes without a skipped pixel.
- Assert rst_n=0 at hcnt=300, vcnt=200 → hsync=1, vsync=1, rgb=0 at once. After release the counters restart at (0,0).
- char 8'h30 → rendered as blank.
